// File: rtl/mux_pkt_arbiter_if.sv
// Flit-mux handshake bundle: per-port flit type/valid and downstream ready in,
// registered mux select, per-port grants and the combinational transfer strobe out.
interface mux_pkt_arbiter_if #(
   parameter int TYPEW = 2,
   parameter int SELW  = 5
);
   logic [TYPEW-1:0] itype_0;
   logic             ivalid_0;
   logic [TYPEW-1:0] itype_1;
   logic             ivalid_1;
   logic             ordy;
   logic [SELW-1:0]  sel;
   logic             grant_0;
   logic             grant_1;
   logic             xfer;

   modport master (
      output itype_0, ivalid_0, itype_1, ivalid_1, ordy,
      input  sel, grant_0, grant_1, xfer
   );

   modport slave (
      input  itype_0, ivalid_0, itype_1, ivalid_1, ordy,
      output sel, grant_0, grant_1, xfer
   );
endinterface

// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter steering a 2:1 flit mux: holds the granted
// port from HEAD to TAIL, with a stall watchdog and per-port packet counters.
module mux_pkt_arbiter #(
   parameter int TYPEW   = 2,
   parameter int SELW    = 5,
   parameter int TIMEOUT = 16,
   parameter int CNTW    = 16
) (
   input  logic             clk,
   input  logic             rst_,
   mux_pkt_arbiter_if.slave bus,
   output logic             err_timeout,
   output logic             err_proto,
   output logic [CNTW-1:0]  pkt_cnt_0,
   output logic [CNTW-1:0]  pkt_cnt_1
);
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
   localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   state_t            state, state_nx;
   logic [SELW-1:0]   sel_q, sel_nx;
   logic              prio, prio_nx;
   logic [WDW-1:0]    wdog, wdog_nx;
   logic              mid, mid_nx;
   logic              err_t_nx, err_p_nx;
   logic              inc_0, inc_1;
   logic              win;

   logic              owner;
   logic              own_valid;
   logic [TYPEW-1:0]  own_type;
   logic              req_0, req_1, other_req;
   logic              xfer_c;

   assign owner     = (state == BUSY1);
   assign own_valid = owner ? bus.ivalid_1 : bus.ivalid_0;
   assign own_type  = owner ? bus.itype_1 : bus.itype_0;
   assign req_0     = bus.ivalid_0 && (bus.itype_0 == T_HEAD);
   assign req_1     = bus.ivalid_1 && (bus.itype_1 == T_HEAD);
   assign other_req = owner ? req_0 : req_1;
   assign xfer_c    = (state != IDLE) && own_valid && bus.ordy;

   assign bus.xfer    = xfer_c;
   assign bus.sel     = sel_q;
   assign bus.grant_0 = (state == BUSY0);
   assign bus.grant_1 = (state == BUSY1);

   // The packet's own HEAD is its first transfer; `mid` marks that it has gone,
   // so only a later HEAD from the owner counts as a protocol error.
   always_comb begin
      state_nx = state;
      sel_nx   = sel_q;
      prio_nx  = prio;
      wdog_nx  = wdog;
      mid_nx   = mid;
      err_t_nx = 1'b0;
      err_p_nx = 1'b0;
      inc_0    = 1'b0;
      inc_1    = 1'b0;
      win      = 1'b0;
      case (state)
         IDLE: begin
            if (req_0 || req_1) begin
               win      = (req_0 && req_1) ? prio : req_1;
               state_nx = win ? BUSY1 : BUSY0;
               sel_nx   = SELW'(win);
               wdog_nx  = '0;
               mid_nx   = 1'b0;
            end
         end
         BUSY0, BUSY1: begin
            if (xfer_c) begin
               wdog_nx = '0;
               if (own_type == T_TAIL) begin
                  inc_0   = !owner;
                  inc_1   = owner;
                  prio_nx = !owner;
                  mid_nx  = 1'b0;
                  if (other_req) begin
                     state_nx = owner ? BUSY0 : BUSY1;
                     sel_nx   = SELW'(!owner);
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  err_p_nx = mid && (own_type == T_HEAD);
                  mid_nx   = 1'b1;
               end
            end else if ((TIMEOUT != 0) && (wdog == WDW'(TIMEOUT - 1))) begin
               state_nx = IDLE;
               err_t_nx = 1'b1;
               prio_nx  = !owner;
            end else begin
               wdog_nx = wdog + WDW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state       <= IDLE;
         sel_q       <= '0;
         prio        <= 1'b0;
         wdog        <= '0;
         mid         <= 1'b0;
         err_timeout <= 1'b0;
         err_proto   <= 1'b0;
         pkt_cnt_0   <= '0;
         pkt_cnt_1   <= '0;
      end else begin
         state       <= state_nx;
         sel_q       <= sel_nx;
         prio        <= prio_nx;
         wdog        <= wdog_nx;
         mid         <= mid_nx;
         err_timeout <= err_t_nx;
         err_proto   <= err_p_nx;
         if (inc_0) pkt_cnt_0 <= pkt_cnt_0 + CNTW'(1);
         if (inc_1) pkt_cnt_1 <= pkt_cnt_1 + CNTW'(1);
      end
   end
endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Scoreboard bench for mux_pkt_arbiter: directed scenarios plus randomized
// packet traffic, compared against a cycle-level behavioural model.
module tb_mux_pkt_arbiter;
   localparam int TIMEOUT = 8;
   localparam logic [1:0] NONE = 2'd0;
   localparam logic [1:0] HEAD = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] TAIL = 2'd3;

   logic        clk = 1'b0;
   logic        rst_;
   logic        err_timeout, err_proto;
   logic [15:0] pkt_cnt_0, pkt_cnt_1;

   mux_pkt_arbiter_if #(.TYPEW(2), .SELW(5)) ifc ();

   mux_pkt_arbiter #(.TYPEW(2), .SELW(5), .TIMEOUT(TIMEOUT), .CNTW(16)) dut (
      .clk(clk),
      .rst_(rst_),
      .bus(ifc),
      .err_timeout(err_timeout),
      .err_proto(err_proto),
      .pkt_cnt_0(pkt_cnt_0),
      .pkt_cnt_1(pkt_cnt_1)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit chk; bit g0; bit g1; int sel; bit xf; bit et; bit ep; int c0; int c1;
   } exp_t;
   typedef struct { int port; logic [1:0] kind; } flit_t;

   exp_t       expq[$];
   flit_t      flitexp[$];
   logic [1:0] src0[$];
   logic [1:0] src1[$];

   int checks = 0, errors = 0;
   int xfer_seen = 0, errt_seen = 0, errp_seen = 0;

   // Reference model: who owns the mux, rotation priority, idle-cycle count.
   bit m_known = 0;
   int m_owner = -1, m_sel = 0, m_prio = 0, m_wd = 0;
   bit m_et = 0, m_ep = 0, m_mid = 0;
   int m_cnt[2] = '{0, 0};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, act, want, $time);
      end
   endtask

   task automatic sendPkt(input int port, input int ndata, input bit bad_head, input bit noisy);
      logic [1:0] body;
      if (port == 0) src0.push_back(HEAD); else src1.push_back(HEAD);
      for (int k = 0; k < ndata; k++) begin
         body = (noisy && $urandom_range(0, 7) == 0) ? NONE : DATA;
         if (bad_head && k == ndata / 2) body = HEAD;
         if (port == 0) src0.push_back(body); else src1.push_back(body);
      end
      if (port == 0) src0.push_back(TAIL); else src1.push_back(TAIL);
   endtask

   // Drive one cycle, push its expected response, then advance the model.
   task automatic applyStimulus(input bit rst_n, input bit rdy, input bit hold0, input bit hold1);
      exp_t e;
      flit_t f;
      bit v0, v1, xf, req0, req1;
      logic [1:0] t0, t1, tt;
      int o;
      v0 = (src0.size() > 0) && !hold0;
      v1 = (src1.size() > 0) && !hold1;
      t0 = (src0.size() > 0) ? src0[0] : NONE;
      t1 = (src1.size() > 0) ? src1[0] : NONE;
      ifc.ivalid_0 = v0; ifc.itype_0 = t0;
      ifc.ivalid_1 = v1; ifc.itype_1 = t1;
      ifc.ordy = rdy;
      rst_ = rst_n;
      o  = m_owner;
      xf = ((o == 0) && v0 && rdy) || ((o == 1) && v1 && rdy);
      tt = (o == 1) ? t1 : t0;
      e.chk = m_known; e.g0 = (o == 0); e.g1 = (o == 1); e.sel = m_sel; e.xf = xf;
      e.et = m_et; e.ep = m_ep; e.c0 = m_cnt[0]; e.c1 = m_cnt[1];
      expq.push_back(e);
      if (xf) begin
         f.port = o; f.kind = tt;
         flitexp.push_back(f);
         if (o == 0) src0.delete(0); else src1.delete(0);
      end
      req0 = v0 && (t0 == HEAD);
      req1 = v1 && (t1 == HEAD);
      m_et = 0; m_ep = 0;
      if (!rst_n) begin
         m_owner = -1; m_sel = 0; m_prio = 0; m_wd = 0; m_mid = 0;
         m_cnt[0] = 0; m_cnt[1] = 0; m_known = 1;
      end else if (m_owner < 0) begin
         if (req0 || req1) begin
            m_owner = (req0 && req1) ? m_prio : (req0 ? 0 : 1);
            m_sel = m_owner; m_wd = 0; m_mid = 0;
         end
      end else if (xf) begin
         m_wd = 0;
         if (tt == TAIL) begin
            m_cnt[o] = (m_cnt[o] + 1) % 65536;
            m_prio = 1 - o; m_mid = 0;
            if ((o == 0) ? req1 : req0) begin m_owner = 1 - o; m_sel = m_owner; end
            else m_owner = -1;
         end else begin
            m_ep = m_mid && (tt == HEAD);
            m_mid = 1;
         end
      end else if (m_wd == TIMEOUT - 1) begin
         m_owner = -1; m_et = 1; m_prio = 1 - o;
      end else begin
         m_wd++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runCycles(input int n, input bit rdy, input bit hold0, input bit hold1);
      for (int k = 0; k < n; k++) applyStimulus(1'b1, rdy, hold0, hold1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      flit_t f;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         if (e.chk) begin
            checkOutput("grant_0", 32'(ifc.grant_0), 32'(e.g0));
            checkOutput("grant_1", 32'(ifc.grant_1), 32'(e.g1));
            checkOutput("sel", 32'(ifc.sel), e.sel);
            checkOutput("xfer", 32'(ifc.xfer), 32'(e.xf));
            checkOutput("err_timeout", 32'(err_timeout), 32'(e.et));
            checkOutput("err_proto", 32'(err_proto), 32'(e.ep));
            checkOutput("pkt_cnt_0", 32'(pkt_cnt_0), e.c0);
            checkOutput("pkt_cnt_1", 32'(pkt_cnt_1), e.c1);
         end
      end
      if (ifc.xfer === 1'b1) begin
         xfer_seen++;
         if (flitexp.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL flit_extra: actual unexpected transfer required none at %0t", $time);
         end else begin
            f = flitexp.pop_front();
            checkOutput("flit_port", 32'(ifc.grant_1), f.port);
            checkOutput("flit_type", 32'(ifc.grant_1 ? ifc.itype_1 : ifc.itype_0), 32'(f.kind));
         end
      end
      if (err_timeout === 1'b1) errt_seen++;
      if (err_proto === 1'b1) errp_seen++;
   end

   initial begin
      int base;
      bit rn, rdy, h0, h1;
      rst_ = 1'b0;
      ifc.ivalid_0 = 1'b0; ifc.itype_0 = NONE;
      ifc.ivalid_1 = 1'b0; ifc.itype_1 = NONE;
      ifc.ordy = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] reset with both HEADs pending, then round-robin hand-over");
      sendPkt(0, 3, 0, 0); sendPkt(1, 2, 0, 0); sendPkt(0, 1, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runCycles(16, 1'b1, 1'b0, 1'b0);
      checkOutput("t3_cnt0", 32'(pkt_cnt_0), 2);
      checkOutput("t3_cnt1", 32'(pkt_cnt_1), 1);

      $display("[TB] long packet on port 1");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      base = xfer_seen;
      sendPkt(1, 20, 0, 0);
      runCycles(26, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_xfer_count", xfer_seen - base, 22);
      checkOutput("t2_cnt1", 32'(pkt_cnt_1), 1);

      $display("[TB] watchdog release");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      sendPkt(0, 4, 0, 0); sendPkt(1, 2, 0, 0);
      runCycles(4, 1'b1, 1'b0, 1'b0);
      base = errt_seen;
      runCycles(TIMEOUT, 1'b1, 1'b1, 1'b0);
      src0.delete();
      runCycles(8, 1'b1, 1'b0, 1'b0);
      checkOutput("t4_err_timeout_pulses", errt_seen - base, 1);
      checkOutput("t4_cnt0", 32'(pkt_cnt_0), 0);
      checkOutput("t4_cnt1", 32'(pkt_cnt_1), 1);

      $display("[TB] downstream stall mid-packet");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      base = errt_seen;
      sendPkt(0, 6, 0, 0);
      runCycles(3, 1'b1, 1'b0, 1'b0);
      runCycles(5, 1'b0, 1'b0, 1'b0);
      runCycles(8, 1'b1, 1'b0, 1'b0);
      checkOutput("t5_no_timeout", errt_seen - base, 0);
      checkOutput("t5_cnt0", 32'(pkt_cnt_0), 1);

      $display("[TB] HEAD on owner mid-packet, then reset while port 1 owns");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      base = errp_seen;
      sendPkt(0, 2, 1, 0);
      runCycles(7, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_err_proto_pulses", errp_seen - base, 1);
      checkOutput("t6_cnt0", 32'(pkt_cnt_0), 1);
      sendPkt(1, 5, 0, 0);
      runCycles(3, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_grant1_before_rst", 32'(ifc.grant_1), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      src0.delete(); src1.delete();
      checkOutput("t6_sel_after_rst", 32'(ifc.sel), 0);
      checkOutput("t6_grant1_after_rst", 32'(ifc.grant_1), 0);
      checkOutput("t6_cnt1_after_rst", 32'(pkt_cnt_1), 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         if (src0.size() == 0 && $urandom_range(0, 3) == 0)
            sendPkt(0, $urandom_range(0, 6), $urandom_range(0, 15) == 0, 1'b1);
         if (src1.size() == 0 && $urandom_range(0, 3) == 0)
            sendPkt(1, $urandom_range(0, 6), $urandom_range(0, 15) == 0, 1'b1);
         rn  = $urandom_range(0, 299) != 0;
         rdy = $urandom_range(0, 3) != 0;
         h0  = $urandom_range(0, 4) == 0;
         h1  = $urandom_range(0, 4) == 0;
         // Keep stalls short so random traffic never trips the watchdog.
         if (m_owner >= 0 && m_wd >= 3) begin rdy = 1; h0 = 0; h1 = 0; end
         applyStimulus(rn, rdy, h0, h1);
         if (!rn) begin src0.delete(); src1.delete(); end
      end
      runCycles(2, 1'b1, 1'b1, 1'b1);
      checkOutput("flit_left", flitexp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
